wb_bram_ctrl: RTL and testbench

Wishbone classic slave that services Caravel user-project memory requests by driving the single-port byte-writable BRAM (CLK/WE0/EN0/Di0/Do0/A0 port, one-cycle registered read, Do0 forced to zero while EN0 is low). It sits between the management-SoC Wishbone bus and the user BRAM. It inserts a programmable access latency, issues exactly one BRAM strobe per transaction and returns a single-cycle acknowledge with read data.

---
 rtl/wb_bram_ctrl.sv | 129 ++++++++++++
 tb/tb_wb_bram_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave that front-ends a single-port byte-writable BRAM with a
// programmable access latency. Optional address window check: WB_BRAM_CTRL_RANGE_CHECK_EN.
module wb_bram_ctrl #(
  parameter int unsigned DELAY     = 10,
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int unsigned N         = 13
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        EN0,
  output logic [3:0]  WE0,
  output logic [31:0] A0,
  output logic [31:0] Di0,
  input  logic [31:0] Do0
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] EN_AT  = CW'(DELAY - 2);
  localparam logic [CW-1:0] ACK_AT = CW'(DELAY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [N-1:0]  idx_q;
  logic [31:0]   dat_q;

  logic [31:0]   offset_c;
  logic [N-1:0]  idx_c;
  logic          hit_c;
  logic          req_c;

  // Word index relative to the window base; upper bits fall away in the truncation.
  assign offset_c = wbs_adr_i - BASE_ADDR;
  assign idx_c    = N'(offset_c >> 2);

`ifdef WB_BRAM_CTRL_RANGE_CHECK_EN
  assign hit_c = (wbs_adr_i[31:N+2] == BASE_ADDR[31:N+2]);
`else
  assign hit_c = 1'b1;
`endif

  assign req_c = wbs_cyc_i & wbs_stb_i & hit_c;

  // Bus FSM; BRAM strobe and ack are single-cycle pulses defaulting to zero each edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      idx_q     <= '0;
      dat_q     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      EN0       <= 1'b0;
      WE0       <= '0;
      A0        <= '0;
      Di0       <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      EN0       <= 1'b0;
      WE0       <= '0;
      A0        <= '0;
      Di0       <= '0;
      case (state)
        S_IDLE: begin
          if (req_c) begin
            state <= S_WAIT;
            cnt   <= CW'(1);
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            idx_q <= idx_c;
            dat_q <= wbs_dat_i;
            // Shortest latency: the BRAM strobe must launch on the accept edge itself.
            if (DELAY == 2) begin
              EN0 <= 1'b1;
              WE0 <= wbs_we_i ? wbs_sel_i : 4'h0;
              A0  <= 32'(idx_c);
              Di0 <= wbs_we_i ? wbs_dat_i : 32'h0;
            end
          end
        end
        S_WAIT: begin
          if (!wbs_cyc_i) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == ACK_AT) begin
            state     <= S_ACK;
            cnt       <= '0;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= we_q ? 32'h0 : Do0;
          end else begin
            if (cnt == EN_AT) begin
              EN0 <= 1'b1;
              WE0 <= we_q ? sel_q : 4'h0;
              A0  <= 32'(idx_q);
              Di0 <= we_q ? dat_q : 32'h0;
            end
            cnt <= cnt + CW'(1);
          end
        end
        S_ACK: begin
          // Recovery cycle: never accepts, even with stb still high.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Directed bench for wb_bram_ctrl: DELAY=10 and DELAY=2 instances, each with a BRAM model.
module tb_wb_bram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic        ack  [2];
  logic [31:0] rdat [2];
  logic        en   [2];
  logic [3:0]  we0  [2];
  logic [31:0] a0   [2];
  logic [31:0] di   [2];
  logic [31:0] do0  [2];
  logic [31:0] mem  [2][8192];

  int checks = 0;
  int errors = 0;

  wb_bram_ctrl #(.DELAY(10)) dut0 (
    .CLK(clk), .RST_N(rst_n),
    .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
    .wbs_adr_i(adr[0]), .wbs_dat_i(wdat[0]), .wbs_ack_o(ack[0]), .wbs_dat_o(rdat[0]),
    .EN0(en[0]), .WE0(we0[0]), .A0(a0[0]), .Di0(di[0]), .Do0(do0[0])
  );

  wb_bram_ctrl #(.DELAY(2)) dut1 (
    .CLK(clk), .RST_N(rst_n),
    .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
    .wbs_adr_i(adr[1]), .wbs_dat_i(wdat[1]), .wbs_ack_o(ack[1]), .wbs_dat_o(rdat[1]),
    .EN0(en[1]), .WE0(we0[1]), .A0(a0[1]), .Di0(di[1]), .Do0(do0[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-writable BRAM, registered read, output register cleared on edges with EN0 low.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (en[u]) begin
        for (int b = 0; b < 4; b++)
          if (we0[u][b]) mem[u][a0[u][12:0]][8*b +: 8] <= di[u][8*b +: 8];
        do0[u] <= mem[u][a0[u][12:0]];
      end else begin
        do0[u] <= '0;
      end
    end
  end

  function automatic int dly(input int u);
    return (u == 0) ? 10 : 2;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drop(input int u);
    cyc[u] = 1'b0;
    stb[u] = 1'b0;
  endtask

  // Present a request at a negedge while the slave is idle; returns just after accept edge E0.
  task automatic issue(input int u, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; sel[u] = s; adr[u] = a; wdat[u] = d;
    @(posedge clk);
  endtask

  // Count acks and strobes over n negedges, dropping cyc at negedge drop_k if >= 0.
  task automatic watch(input int u, input int n, input int drop_k,
                       output int n_ack, output int n_en);
    n_ack = 0;
    n_en  = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (ack[u]) n_ack++;
      if (en[u]) n_en++;
      if (k == drop_k) drop(u);
    end
  endtask

  // Full transaction with latency, strobe and data checks.
  task automatic txn(input int u, input logic w, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_a0, input logic [3:0] exp_we,
                     input bit chk_rd, input logic [31:0] exp_rd);
    int dl, ack_k, en_k, en_n;
    logic [31:0] a0s, dis, rd;
    logic [3:0] wes;
    logic bad;
    dl = dly(u); ack_k = -1; en_k = -1; en_n = 0; bad = 1'b0;
    a0s = '0; dis = '0; rd = '0; wes = '0;
    issue(u, w, s, a, d);
    for (int k = 0; k < 300 && ack_k < 0; k++) begin
      @(negedge clk);
      if (en[u]) begin
        en_n++; en_k = k; a0s = a0[u]; wes = we0[u]; dis = di[u];
      end else if (a0[u] != 0 || we0[u] != 0 || di[u] != 0) begin
        bad = 1'b1;
      end
      if (ack[u]) begin
        ack_k = k; rd = rdat[u];
      end
    end
    drop(u);
    check("ack_latency", 32'(ack_k), 32'(dl));
    check("en0_count", 32'(en_n), 32'd1);
    check("en0_position", 32'(en_k), 32'(dl - 2));
    check("a0", a0s, exp_a0);
    check("we0", {28'h0, wes}, {28'h0, exp_we});
    if (w) check("di0", dis, d);
    check("idle_strobe_zero", {31'h0, bad}, 32'h0);
    if (chk_rd) check("ack_rdata", rd, exp_rd);
    @(negedge clk);
    check("ack_cleared", {31'h0, ack[u]}, 32'h0);
    check("rdata_cleared", rdat[u], 32'h0);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_a0;
    logic [3:0]  exp_we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [11];

  initial begin
    int na, ne, ack1, ack2, nack, nen;
    logic [31:0] r1, r2;

    vt[0]  = '{1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 32'd4,      4'hF, 32'h0};
    vt[1]  = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         32'd4,      4'h0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 4'h5, 32'h3800_0010, 32'h1122_3344, 32'd4,      4'h5, 32'h0};
    vt[3]  = '{1'b0, 4'hF, 32'h3800_0010, 32'h0,         32'd4,      4'h0, 32'hDE22_BE44};
    vt[4]  = '{1'b1, 4'hF, 32'h3800_0024, 32'h0BAD_F00D, 32'd9,      4'hF, 32'h0};
    vt[5]  = '{1'b1, 4'h0, 32'h3800_0024, 32'hFFFF_FFFF, 32'd9,      4'h0, 32'h0};
    vt[6]  = '{1'b0, 4'hF, 32'h3800_0024, 32'h0,         32'd9,      4'h0, 32'h0BAD_F00D};
    vt[7]  = '{1'b1, 4'hF, 32'h3800_7FFC, 32'hA5A5_5A5A, 32'h1FFF,   4'hF, 32'h0};
    vt[8]  = '{1'b0, 4'hF, 32'h3800_7FFC, 32'h0,         32'h1FFF,   4'h0, 32'hA5A5_5A5A};
    vt[9]  = '{1'b1, 4'hA, 32'h3800_7FFC, 32'h00FF_00FF, 32'h1FFF,   4'hA, 32'h0};
    vt[10] = '{1'b0, 4'hF, 32'h3800_7FFC, 32'h0,         32'h1FFF,   4'h0, 32'h00A5_005A};

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      cyc[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0; sel[u] = '0; adr[u] = '0; wdat[u] = '0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ack", {31'h0, ack[0]}, 32'h0);
    check("rst_rdata", rdat[0], 32'h0);
    check("rst_en0", {31'h0, en[0]}, 32'h0);
    check("rst_we0", {28'h0, we0[0]}, 32'h0);
    check("rst_a0", a0[0], 32'h0);
    check("rst_di0", di[0], 32'h0);
    check("rst_en0_d2", {31'h0, en[1]}, 32'h0);
    rst_n = 1'b1;

    // Reset asserted mid-WAIT drops the pending write
    txn(0, 1'b1, 4'hF, 32'h3800_0000, 32'h600D_D00D, 32'd0, 4'hF, 1'b1, 32'h0);
    issue(0, 1'b1, 4'hF, 32'h3800_0000, 32'h1234_5678);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midwait_rst_ack", {31'h0, ack[0]}, 32'h0);
    check("midwait_rst_en0", {31'h0, en[0]}, 32'h0);
    check("midwait_rst_a0", a0[0], 32'h0);
    drop(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    watch(0, 15, -1, na, ne);
    check("midwait_rst_no_ack", 32'(na), 32'd0);
    check("midwait_rst_no_en0", 32'(ne), 32'd0);
    txn(0, 1'b0, 4'hF, 32'h3800_0000, 32'h0, 32'd0, 4'h0, 1'b1, 32'h600D_D00D);

    // Directed vector table on the DELAY=10 instance
    for (int i = 0; i < 11; i++)
      txn(0, vt[i].w, vt[i].s, vt[i].a, vt[i].d, vt[i].exp_a0, vt[i].exp_we, 1'b1, vt[i].exp_rd);

    // Back-to-back with stb held through the ack: accepts at E0 and E12
    ack1 = -1; ack2 = -1; nack = 0; nen = 0; r1 = '0; r2 = '0;
    issue(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (en[0]) nen++;
      if (ack[0]) begin
        nack++;
        if (ack1 < 0) begin ack1 = k; r1 = rdat[0]; end
        else if (ack2 < 0) begin ack2 = k; r2 = rdat[0]; drop(0); end
      end
    end
    drop(0);
    check("b2b_first_ack", 32'(ack1), 32'd10);
    check("b2b_second_ack", 32'(ack2), 32'd22);
    check("b2b_ack_count", 32'(nack), 32'd2);
    check("b2b_en0_count", 32'(nen), 32'd2);
    check("b2b_rdata1", r1, 32'hDE22_BE44);
    check("b2b_rdata2", r2, 32'hDE22_BE44);

    // Abort before the strobe: no access, old data survives
    issue(0, 1'b1, 4'hF, 32'h3800_0010, 32'h9999_9999);
    watch(0, 25, 3, na, ne);
    check("abort_no_ack", 32'(na), 32'd0);
    check("abort_no_en0", 32'(ne), 32'd0);
    txn(0, 1'b0, 4'hF, 32'h3800_0010, 32'h0, 32'd4, 4'h0, 1'b1, 32'hDE22_BE44);

    // DELAY=2: strobe on the accept edge; abort after E0 still commits the write
    txn(1, 1'b1, 4'hF, 32'h3800_0040, 32'h0101_0101, 32'd16, 4'hF, 1'b1, 32'h0);
    txn(1, 1'b0, 4'hF, 32'h3800_0040, 32'h0, 32'd16, 4'h0, 1'b1, 32'h0101_0101);
    issue(1, 1'b1, 4'hF, 32'h3800_0040, 32'h7E7E_7E7E);
    watch(1, 10, 0, na, ne);
    check("abort_d2_no_ack", 32'(na), 32'd0);
    check("abort_d2_en0", 32'(ne), 32'd1);
    txn(1, 1'b0, 4'hF, 32'h3800_0040, 32'h0, 32'd16, 4'h0, 1'b1, 32'h7E7E_7E7E);

    // Out-of-window read
`ifdef WB_BRAM_CTRL_RANGE_CHECK_EN
    issue(0, 1'b0, 4'hF, 32'h3000_0000, 32'h0);
    watch(0, 50, 49, na, ne);
    check("range_no_ack", 32'(na), 32'd0);
    check("range_no_en0", 32'(ne), 32'd0);
`else
    txn(0, 1'b0, 4'hF, 32'h3000_0000, 32'h0, 32'd0, 4'h0, 1'b0, 32'h0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
